hex_scroll_ctrl: RTL and testbench
==================================

# hex_scroll_ctrl

Message scroller that drives a bank of seven-segment decoders with 4-bit glyph codes. It holds a small writable message buffer and presents a NUM_DIGITS-wide window onto it. On each prescaled tick the window advances one position, with wrap-around, so that text such as "HELLO" scrolls across the HEX displays. Each 4-bit slice of `codes` feeds one SevSegDec4to7 instance directly.

## Interface
- `NUM_DIGITS`, default 6: number of displays driven (1..16).
- `MSG_LEN`, default 16: message buffer depth in glyphs; must be a power of two, 2..16.
- `TICK_DIV`, default 25_000_000: clk cycles per scroll step (0.5 s at 50 MHz); must be ≥ 2.
- `clk` in 1: system clock; the block uses one clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins scrolling from offset 0.
- `stop` in 1: single-cycle pulse that returns to idle and blanks the display.
- `pause` in 1: level input; while high, scrolling freezes.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in $clog2(MSG_LEN): buffer write address.
- `wr_code` in 4: glyph code to write.
- `codes` out 4*NUM_DIGITS: registered glyph codes. Digit 0 (leftmost) is `codes[4*NUM_DIGITS-1 -: 4]`.
- `busy` out 1: high in SCROLL or HOLD.
- `wrap` out 1: one-cycle pulse when the offset wraps from MSG_LEN-1 to 0.

## Operation
- Glyph codes: 0–9 are digits; A=H, B=E, C=L, D=O, E=blank, F=F.
- Buffer reset contents: addr 0..4 = A, B, C, C, D ("HELLO"); all other addresses = E.
- Buffer writes are accepted in any state. A write is visible in the buffer the cycle after `wr_en`.
- Offset register `ptr`, width $clog2(MSG_LEN), wraps naturally modulo MSG_LEN.
- Digit i shows `buf[(ptr + i) mod MSG_LEN]`. When NUM_DIGITS > MSG_LEN, the message repeats across the digits.
- States:
  - IDLE: `codes` is all E; `busy`=0; prescaler held at 0.
  - SCROLL: the prescaler counts 0..TICK_DIV-1. A tick occurs at TICK_DIV-1, and on a tick `ptr` increments.
  - HOLD: prescaler and `ptr` are frozen; `codes` keeps tracking the buffer, so writes still show.
- Transitions:
  - IDLE→SCROLL on `start`; `ptr`←0, prescaler←0.
  - SCROLL→HOLD while `pause`=1. HOLD→SCROLL when `pause`=0; the prescaler resumes from its frozen value.
  - SCROLL or HOLD→IDLE on `stop`.
  - `start` in SCROLL or HOLD restarts: `ptr`←0, prescaler←0, next state SCROLL, or HOLD if `pause`=1.
- Simultaneous events:
  - `stop` and `start` together: `stop` wins.
  - `start` and `pause` together from IDLE: enter HOLD with `ptr`=0.
  - A tick and `stop` in the same cycle: `ptr` does not advance.
- `wrap` asserts in the same cycle `ptr` becomes 0 by increment. It does not assert on `start`, `stop` or reset.
- `reset` mid-operation: next cycle the block is in IDLE, `ptr`=0, the buffer is reloaded to "HELLO", and outputs take their reset values.

## Timing
- Reset values: `codes` = all 4'hE, `busy`=0, `wrap`=0, state IDLE, `ptr`=0, prescaler=0.
- `busy` is registered: high the cycle after the state register holds SCROLL or HOLD.
- `codes` is registered from the current `ptr` and buffer. Latency is 1 cycle from a `ptr` or buffer change to `codes`, and 2 cycles from a `start` or `wr_en` edge to the output.
- Step period in continuous SCROLL: exactly TICK_DIV cycles between `ptr` increments. The first increment comes TICK_DIV cycles after `start` is sampled.
- After `stop`, `codes` is all blank 2 cycles after `stop` is sampled.

## Structure
- Package `hex_scroll_pkg` holds:
  - glyph constants `GLYPH_H`=4'hA, `GLYPH_E`=4'hB, `GLYPH_L`=4'hC, `GLYPH_O`=4'hD, `GLYPH_BLANK`=4'hE, `GLYPH_F`=4'hF;
  - the state enum (IDLE, SCROLL, HOLD);
  - the reset message constant.
- Sub-module `tick_prescaler`: parameter DIV; inputs `clk`, `reset`, `en`, `clr`; output `tick`. It holds its count while `en`=0.
- The buffer is a register array, not inferred RAM, because it needs a synchronous reset load.

## Test plan
- Reset, then idle for 10 cycles → `codes` = 24'hEEEEEE, `busy`=0.
- TICK_DIV=4, `start` → 2 cycles later `codes` = 24'hABCCDE. After 4 more cycles `codes` = 24'hBCCDEE. After 16 steps `wrap` pulses once and `codes` returns to 24'hABCCDE.
- Assert `pause` for 10 cycles mid-period → no `ptr` change during the pause. The next step lands exactly (TICK_DIV − elapsed) cycles after `pause` drops.
- In HOLD, write addr 1 = 4'h7 → `codes` digit 1 becomes 7 two cycles later, with no scroll.
- Pulse `start` and `stop` together, and `stop` on a tick cycle → state IDLE, `ptr` unchanged, `codes` = all E two cycles later, `wrap`=0.
- Assert `reset` during SCROLL with a modified buffer → buffer reads "HELLO" again and all outputs return to their reset values.

Source files
------------

// File: rtl/hex_scroll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scroll_pkg
//  Description : Shared glyph codes, scroller state encoding and the message
//                loaded into the buffer at reset ("HELLO").
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_scroll_pkg;

    // Glyph codes understood by the downstream seven-segment decoders.
    // Codes 0-9 are plain digits and need no names.
    localparam logic [3:0] GLYPH_H     = 4'hA;
    localparam logic [3:0] GLYPH_E     = 4'hB;
    localparam logic [3:0] GLYPH_L     = 4'hC;
    localparam logic [3:0] GLYPH_O     = 4'hD;
    localparam logic [3:0] GLYPH_BLANK = 4'hE;
    localparam logic [3:0] GLYPH_F     = 4'hF;

    // Scroller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Message loaded at reset; the first glyph sits at buffer address 0.
    localparam int unsigned          RESET_MSG_LEN = 5;
    localparam logic [4*RESET_MSG_LEN-1:0] RESET_MSG =
        {GLYPH_H, GLYPH_E, GLYPH_L, GLYPH_L, GLYPH_O};

    // Reset content of one buffer address: the message, then blanks.
    function automatic logic [3:0] reset_glyph(input int unsigned addr);
        logic [3:0] glyph;
        glyph = GLYPH_BLANK;
        if (addr < RESET_MSG_LEN) begin
            glyph = RESET_MSG[4*(RESET_MSG_LEN-1-addr) +: 4];
        end
        return glyph;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scroll_ctrl_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divider producing a one-cycle tick every DIV
//                enabled cycles. The count holds while en is low and returns
//                to zero on clr, so a paused period resumes where it stopped.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import hex_scroll_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned          c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_at_last;

    assign w_at_last = (r_count == c_last);

    // Tick is combinational so the consumer acts on the same edge that
    // wraps the count; no extra cycle of latency in the step period.
    assign tick = en && w_at_last;

    // Count 0..DIV-1 while enabled; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (en) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scroll_ctrl
//  Description : Message scroller for a bank of seven-segment decoders.
//                Holds a writable glyph buffer and shows a NUM_DIGITS-wide
//                window onto it, advancing one position per prescaled tick
//                with wrap-around. Start / stop pulses and a pause level
//                control the scroll; the window output is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned MSG_LEN    = 16,
    parameter int unsigned TICK_DIV   = 25_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        pause,
    input  logic                        wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]  wr_addr,
    input  logic [3:0]                  wr_code,
    output logic [4*NUM_DIGITS-1:0]     codes,
    output logic                        busy,
    output logic                        wrap
);

    localparam int unsigned        c_ptr_w    = $clog2(MSG_LEN);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(MSG_LEN - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_chk_digits
            $error("hex_scroll_ctrl: NUM_DIGITS must be 1..16");
        end
        if (MSG_LEN < 2 || MSG_LEN > 16 || (MSG_LEN & (MSG_LEN - 1)) != 0) begin : g_chk_len
            $error("hex_scroll_ctrl: MSG_LEN must be a power of two, 2..16");
        end
        if (TICK_DIV < 2) begin : g_chk_div
            $error("hex_scroll_ctrl: TICK_DIV must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_ptr_w-1:0]     r_ptr;
    logic [3:0]             r_buf [MSG_LEN];
    logic [4*NUM_DIGITS-1:0] r_codes;
    logic [4*NUM_DIGITS-1:0] w_codes_next;
    logic                   r_busy;
    logic                   r_wrap;

    logic w_active;       // state register holds SCROLL or HOLD
    logic w_restart;      // start that is not overridden by stop
    logic w_presc_en;
    logic w_presc_clr;
    logic w_tick;
    logic w_step;         // tick that actually advances the offset

    assign w_active  = (r_state != IDLE);
    assign w_restart = start && !stop;

    // The pause level gates the prescaler directly, so counting freezes on
    // the first paused cycle and resumes on the first unpaused one. That
    // keeps the remaining part of an interrupted period exact.
    assign w_presc_en  = w_active && !pause;
    assign w_presc_clr = !w_active || start || stop;

    // A tick coinciding with start or stop must not move the offset.
    assign w_step = w_tick && !start && !stop;

    // ------------------------------------------------------------------------
    // Step prescaler
    // ------------------------------------------------------------------------
    tick_prescaler #(
        .DIV   (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (w_presc_en),
        .clr   (w_presc_clr),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: stop beats start, pause level picks SCROLL vs HOLD.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_restart) begin
                    w_state_next = pause ? HOLD : SCROLL;
                end
            end
            SCROLL, HOLD: begin
                if (stop) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = pause ? HOLD : SCROLL;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Window offset and wrap pulse
    // ------------------------------------------------------------------------

    // Offset: cleared by start, advanced by a qualified tick, held otherwise
    // (including across stop, so IDLE keeps the last position).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_restart) begin
            r_ptr <= '0;
        end else if (w_step) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Wrap pulse lands on the same edge the offset rolls over to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_step && !w_restart && (r_ptr == c_ptr_last);
        end
    end

    // ------------------------------------------------------------------------
    // Message buffer
    // ------------------------------------------------------------------------

    // Register array so that reset can reload the default message; writes
    // are accepted in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned a = 0; a < MSG_LEN; a++) begin
                r_buf[a] <= reset_glyph(a);
            end
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_code;
        end
    end

    // ------------------------------------------------------------------------
    // Output window
    // ------------------------------------------------------------------------

    // Window gather: digit d reads buf[(ptr + d) mod MSG_LEN]; the cast to
    // the offset width performs the modulo, repeating the message when
    // there are more digits than buffer entries.
    always_comb begin
        w_codes_next = '0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            w_codes_next[4*(NUM_DIGITS-1-d) +: 4] = r_buf[c_ptr_w'(r_ptr + d)];
        end
    end

    // Registered glyph outputs: blank in IDLE, live window otherwise.
    always_ff @(posedge clk) begin
        if (reset || !w_active) begin
            r_codes <= {NUM_DIGITS{GLYPH_BLANK}};
        end else begin
            r_codes <= w_codes_next;
        end
    end

    // Busy follows the state register one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= w_active;
        end
    end

    assign codes = r_codes;
    assign busy  = r_busy;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_scroll_ctrl
//  Description : Self-checking bench for hex_scroll_ctrl (6 digits, 16-entry
//                buffer, 4-cycle step). Directed vector table plus short
//                hand sequences for wrap, stop-on-tick and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scroll_ctrl;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned MSG_LEN    = 16;
    localparam int unsigned TICK_DIV   = 4;
    localparam int          NVEC       = 25;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        pause;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_code;
    logic [23:0] codes;
    logic        busy;
    logic        wrap;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] mbuf [MSG_LEN];

    typedef struct {
        logic        start;
        logic        stop;
        logic        pause;
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [3:0]  wr_code;
        logic [23:0] codes;
        logic        busy;
        logic        wrap;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    hex_scroll_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .MSG_LEN    (MSG_LEN),
        .TICK_DIV   (TICK_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_code (wr_code),
        .codes   (codes),
        .busy    (busy),
        .wrap    (wrap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < MSG_LEN; a++) mbuf[a] = 4'hE;
        mbuf[0] = 4'hA; mbuf[1] = 4'hB; mbuf[2] = 4'hC; mbuf[3] = 4'hC; mbuf[4] = 4'hD;
    endtask

    function automatic logic [23:0] win(input int p);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) r[23-4*i -: 4] = mbuf[(p + i) % MSG_LEN];
        return r;
    endfunction

    function automatic vec_t mk(input logic st, input logic sp, input logic pa,
                                input logic we, input logic [3:0] ad, input logic [3:0] cd,
                                input logic [23:0] c, input logic b, input logic w);
        vec_t v;
        v.start = st; v.stop = sp; v.pause = pa; v.wr_en = we;
        v.wr_addr = ad; v.wr_code = cd; v.codes = c; v.busy = b; v.wrap = w;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrap_cnt;
        int wrap_at;

        // Vector table: inputs sampled on one edge, outputs expected after it.
        //            st    sp    pa    we    addr  code   codes       busy  wrap
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hEEEEEE, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hEEEEEE, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hABCCDE, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hABCCDE, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hABCCDE, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hABCCDE, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hBCCDEE, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 24'hBCCDEE, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'h7, 24'hBCCDEE, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 24'hB7CDEE, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 24'hB7CDEE, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hB7CDEE, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hB7CDEE, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hB7CDEE, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h7CDEEE, 1'b1, 1'b0);
        vecs[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 24'h7CDEEE, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hEEEEEE, 1'b0, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 24'hEEEEEE, 1'b0, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 24'hAB7CDE, 1'b1, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 24'hAB7CDE, 1'b1, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hAB7CDE, 1'b1, 1'b0);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hAB7CDE, 1'b1, 1'b0);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hAB7CDE, 1'b1, 1'b0);
        vecs[23] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 24'hAB7CDE, 1'b1, 1'b0);
        vecs[24] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hEEEEEE, 1'b0, 1'b0);

        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        wr_en = 1'b0; wr_addr = 4'h0; wr_code = 4'h0;
        model_reset();

        // Reset values.
        repeat (3) step();
        chk("reset codes", 32'(codes), 32'h00EEEEEE);
        chk("reset busy",  32'(busy),  32'h0);
        chk("reset wrap",  32'(wrap),  32'h0);

        // Idle for ten cycles.
        reset = 1'b0;
        repeat (10) step();
        chk("idle codes", 32'(codes), 32'h00EEEEEE);
        chk("idle busy",  32'(busy),  32'h0);

        // Table: scroll, pause timing, write in HOLD, start+stop, start+pause,
        // stop on a tick cycle.
        for (int v = 0; v < NVEC; v++) begin
            start   = vecs[v].start;
            stop    = vecs[v].stop;
            pause   = vecs[v].pause;
            wr_en   = vecs[v].wr_en;
            wr_addr = vecs[v].wr_addr;
            wr_code = vecs[v].wr_code;
            step();
            if (vecs[v].wr_en) mbuf[vecs[v].wr_addr] = vecs[v].wr_code;
            chk($sformatf("vec%0d codes", v), 32'(codes), 32'(vecs[v].codes));
            chk($sformatf("vec%0d busy", v),  32'(busy),  32'(vecs[v].busy));
            chk($sformatf("vec%0d wrap", v),  32'(wrap),  32'(vecs[v].wrap));
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0; wr_en = 1'b0;

        // Full revolution: 16 steps, exactly one wrap on the 64th cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        wrap_cnt = 0;
        wrap_at  = -1;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (wrap === 1'b1) begin
                wrap_cnt++;
                wrap_at = k;
            end
            if (k == 5) chk("rev step1 codes", 32'(codes), 32'(win(1)));
        end
        chk("rev wrap count", 32'(wrap_cnt), 32'd1);
        chk("rev wrap cycle", 32'(wrap_at),  32'd64);
        step();
        chk("rev back codes", 32'(codes), 32'(win(0)));
        chk("rev wrap low",   32'(wrap),  32'h0);

        // Stop on the tick that would wrap 15 -> 0: no wrap, blank display.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (61) step();
        chk("ptr15 codes", 32'(codes), 32'(win(15)));
        repeat (2) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stoptick wrap", 32'(wrap), 32'h0);
        chk("stoptick busy", 32'(busy), 32'h1);
        step();
        chk("stoptick wrap2", 32'(wrap),  32'h0);
        chk("stoptick codes", 32'(codes), 32'h00EEEEEE);
        chk("stoptick busy2", 32'(busy),  32'h0);

        // Reset while scrolling with a modified buffer.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("pre-reset codes", 32'(codes), 32'(win(1)));
        reset = 1'b1;
        step();
        model_reset();
        chk("midreset codes", 32'(codes), 32'h00EEEEEE);
        chk("midreset busy",  32'(busy),  32'h0);
        chk("midreset wrap",  32'(wrap),  32'h0);
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("reload codes", 32'(codes), 32'h00ABCCDE);
        chk("reload model", 32'(codes), 32'(win(0)));
        chk("reload busy",  32'(busy),  32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
